// File: rtl/pair_exit_scheduler.sv
// pair_exit_scheduler: round-robin collects filter-lane pair records into a shared queue and releases one per frame.
module pair_exit_scheduler #(
  parameter int N_LANES = 14,
  parameter int W       = 227,
  parameter int FRAME   = 16,
  parameter int DEPTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_LANES-1:0]       lane_valid,
  input  logic [N_LANES*W-1:0]     lane_data,
  output logic [N_LANES-1:0]       lane_ready,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  output logic                     frame_tick,
  output logic                     qempty,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int LW = $clog2(N_LANES);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FRAME);
  localparam logic [W-1:0] NULL_REC = {1'b1, {(W-1){1'b0}}};

  logic [FW-1:0]      cnt;
  logic [LW-1:0]      rr_ptr, g;
  logic [AW-1:0]      wptr, rptr;
  logic [AW:0]        count;
  logic [W-1:0]       mem [DEPTH];
  logic [N_LANES-1:0] grant;
  logic               hit, issue, push, pop;

  // Grant is decided from the pre-pop count, so a full queue refuses even when the issue slot pops.
  always_comb begin
    int idx;
    idx = 0;
    grant = '0;
    g = '0;
    hit = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_LANES) idx = idx - N_LANES;
      if (!hit && lane_valid[idx]) begin
        hit = 1'b1;
        g = LW'(idx);
      end
    end
    grant[g] = hit && !reset && (count < (AW+1)'(DEPTH));
  end

  assign lane_ready = grant;
  assign push       = |grant;
  assign issue      = cnt == FW'(FRAME-1);
  assign pop        = issue && (count != '0);
  assign occupancy  = count;

  always_ff @(posedge clk)
    if (push) mem[wptr] <= lane_data[int'(g)*W +: W];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= FW'(FRAME-1);
      rr_ptr     <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      out_data   <= NULL_REC;
      out_valid  <= 1'b0;
      qempty     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= issue ? '0 : cnt + 1'b1;
      frame_tick <= issue;
      count      <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (push) begin
        wptr   <= wptr + 1'b1;
        rr_ptr <= (g == LW'(N_LANES-1)) ? '0 : g + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (issue) begin
        out_data  <= pop ? mem[rptr] : NULL_REC;
        out_valid <= pop;
        qempty    <= !pop;
      end
    end
  end
endmodule

// File: tb/tb_pair_exit_scheduler.sv
// tb_pair_exit_scheduler: directed stimulus with a queue scoreboard checked by a decoupled output monitor.
module tb_pair_exit_scheduler;
  localparam int N = 14;
  localparam int W = 227;
  localparam int DEPTH = 32;
  localparam logic [W-1:0] NULL_REC = {1'b1, {(W-1){1'b0}}};

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     lane_valid = '0;
  logic [N*W-1:0]   lane_data = '0;
  logic [N-1:0]     lane_ready;
  logic [W-1:0]     out_data;
  logic             out_valid, frame_tick, qempty;
  logic [5:0]       occupancy;

  pair_exit_scheduler #(.N_LANES(N), .W(W), .FRAME(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .lane_valid(lane_valid), .lane_data(lane_data),
    .lane_ready(lane_ready), .out_data(out_data), .out_valid(out_valid),
    .frame_tick(frame_tick), .qempty(qempty), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  logic [W-1:0] lane_q [N][$];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_out;
  logic         rst_q;
  int n_chk = 0, n_pass = 0, m_chk = 0, m_pass = 0;
  int phase = 0;

  always @(posedge clk) rst_q <= reset;

  // Output monitor: scoreboard pop on each real release, hold check elsewhere.
  initial forever begin
    @(negedge clk);
    if (rst_q !== 1'b0) last_out = out_data;
    else if (frame_tick) begin
      if (out_valid) begin
        m_chk++;
        if (exp_q.size() == 0) $display("FAIL release: got %h required nothing queued", out_data);
        else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (out_data === e) m_pass++;
          else $display("FAIL release: got %h required %h", out_data, e);
        end
      end
      last_out = out_data;
    end else begin
      m_chk++;
      if (out_data === last_out) m_pass++;
      else $display("FAIL hold: got %h required %h", out_data, last_out);
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, expv);
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      lane_valid[i] = lane_q[i].size() > 0;
      lane_data[i*W +: W] = (lane_q[i].size() > 0) ? lane_q[i][0] : '0;
    end
  endtask

  task automatic step();
    logic [N-1:0] xfer;
    logic rs;
    @(negedge clk);
    xfer = lane_valid & lane_ready;
    rs = reset;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (xfer[i]) void'(lane_q[i].pop_front());
    refresh();
    phase = rs ? 15 : (phase == 15 ? 0 : phase + 1);
  endtask

  task automatic to_phase(input int p);
    for (int i = 0; i < 16 && phase != p; i++) step();
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() > 0; i++) step();
    chk("drain", W'(exp_q.size()), '0);
  endtask

  initial begin
    refresh();
    repeat (3) step();
    reset = 1'b0;
    #1;
    // Reset state: first post-reset cycle is the issue slot on an empty queue.
    chk("rst_out_data", out_data, NULL_REC);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_qempty", W'(qempty), W'(1));
    chk("rst_occupancy", W'(occupancy), '0);
    chk("rst_frame_tick", W'(frame_tick), '0);
    step();
    chk("first_frame_tick", W'(frame_tick), W'(1));
    chk("first_release_null", out_data, NULL_REC);
    chk("first_qempty", W'(qempty), W'(1));

    // Single record from lane 5 at cnt 3.
    to_phase(3);
    lane_q[5].push_back(W'(12'hABC));
    refresh();
    #1;
    chk("single_ready", W'(lane_ready), W'(14'h0020));
    exp_q.push_back(W'(12'hABC));
    step();
    chk("single_occ", W'(occupancy), W'(1));
    to_phase(0);
    chk("single_valid", W'(out_valid), W'(1));
    chk("single_qempty", W'(qempty), '0);
    step();
    to_phase(0);
    chk("single_null_data", out_data, NULL_REC);
    chk("single_null_valid", W'(out_valid), '0);
    chk("single_null_qempty", W'(qempty), W'(1));

    // Fairness: rr_ptr is 6 after lane 5, so lane 13 wins first, then 0, 3, 13, 0, 3.
    begin
      int order [6] = '{13, 0, 3, 13, 0, 3};
      for (int r = 0; r < 2; r++) begin
        lane_q[0].push_back(W'(32'hA000 + r));
        lane_q[3].push_back(W'(32'hB000 + r));
        lane_q[13].push_back(W'(32'hC000 + r));
      end
      refresh();
      #1;
      for (int i = 0; i < 6; i++) begin
        exp_q.push_back(W'(32'h1000 * (order[i] == 0 ? 10 : order[i] == 3 ? 11 : 12) + i / 3));
        chk($sformatf("fair_grant%0d", i), W'(lane_ready), W'(1) << order[i]);
        step();
      end
    end
    drain(200);

    // Backpressure: every lane holds 3 records; rr_ptr is 4 after lane 3.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) lane_q[i].push_back(W'(32'h10000 + i * 16 + k));
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < N; j++) exp_q.push_back(W'(32'h10000 + ((4 + j) % N) * 16 + k));
    refresh();
    for (int i = 0; i < 100 && occupancy != 6'(DEPTH); i++) step();
    chk("bp_full", W'(occupancy), W'(DEPTH));
    chk("bp_ready_full", W'(lane_ready), '0);
    to_phase(15);
    chk("bp_ready_issue", W'(lane_ready), '0);
    step();
    chk("bp_occ_after_pop", W'(occupancy), W'(DEPTH - 1));
    chk("bp_grant_resumes", W'(lane_ready != '0), W'(1));
    step();
    chk("bp_refull", W'(occupancy), W'(DEPTH));
    drain(1000);
    chk("bp_lanes_empty", W'(lane_valid), '0);
    chk("bp_occ_zero", W'(occupancy), '0);

    // Same-cycle push and pop at the issue slot.
    to_phase(2);
    lane_q[7].push_back(W'(32'h5EED1));
    exp_q.push_back(W'(32'h5EED1));
    refresh();
    step();
    chk("pp_occ1", W'(occupancy), W'(1));
    to_phase(15);
    lane_q[7].push_back(W'(32'h5EED2));
    exp_q.push_back(W'(32'h5EED2));
    refresh();
    #1;
    chk("pp_ready", W'(lane_ready), W'(1) << 7);
    step();
    chk("pp_occ_same", W'(occupancy), W'(1));
    chk("pp_valid", W'(out_valid), W'(1));
    drain(100);

    // Mid-operation reset with 10 queued and lane 9 mid-grant.
    to_phase(0);
    for (int i = 0; i < 11; i++) lane_q[1].push_back(W'(32'h70000 + i));
    exp_q.push_back(W'(32'h70000));
    refresh();
    repeat (16) step();
    to_phase(7);
    chk("mr_occ10", W'(occupancy), W'(10));
    lane_q[9].push_back(W'(32'h9999));
    reset = 1'b1;
    refresh();
    #1;
    chk("mr_ready_in_reset", W'(lane_ready), '0);
    step();
    chk("mr_occ0", W'(occupancy), '0);
    chk("mr_out_null", out_data, NULL_REC);
    chk("mr_out_valid", W'(out_valid), '0);
    chk("mr_qempty", W'(qempty), W'(1));
    chk("mr_frame_tick", W'(frame_tick), '0);
    reset = 1'b0;
    lane_q[1].push_back(W'(32'h1111));
    exp_q.push_back(W'(32'h1111));
    exp_q.push_back(W'(32'h9999));
    refresh();
    #1;
    chk("mr_rr_restart", W'(lane_ready), W'(1) << 1);
    step();
    chk("mr_regrant", W'(lane_ready), W'(1) << 9);
    chk("mr_issue_empty", W'(out_valid), '0);
    step();
    chk("mr_occ2", W'(occupancy), W'(2));
    drain(100);
    chk("end_occ", W'(occupancy), '0);

    $display("%0d/%0d checks passed", n_pass + m_pass, n_chk + m_chk);
    $finish;
  end
endmodule
